// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector magnitude datapath.
// Q20.11 signed fixed point: 1 sign bit, 20 integer bits, 11 fractional bits.
package vec_pkg;

  localparam int Q_WIDTH = 32;
  localparam int FRAC    = 11;

  typedef logic signed [Q_WIDTH-1:0] fixed_t;

  typedef enum logic [2:0] {
    IDLE,
    SQ_X,
    SQ_Y,
    SUM,
    LOAD,
    RUN,
    DONE
  } vec_state_t;

  localparam logic [Q_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;

  // The most negative word has no positive twin.
  function automatic logic is_min(input fixed_t v);
    return v == fixed_t'(32'h8000_0000);
  endfunction

  // Two's-complement absolute value, clamped so -2^31 becomes 2^31-1.
  function automatic logic [Q_WIDTH-2:0] abs_sat(input fixed_t v);
    return is_min(v) ? Q_MAX[Q_WIDTH-2:0] : (Q_WIDTH-1)'(v[Q_WIDTH-1] ? -v : v);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Unsigned 31x31 sequential shift-add multiplier with a fixed 32-cycle
// latency: start_in is sampled in cycle 1, done_out pulses in cycle 32 with
// prod_out valid from then until the next start.
//   clk_in    system clock
//   rst_in    synchronous active-high reset
//   start_in  load operands (one-cycle pulse)
//   a_in      multiplicand
//   b_in      multiplier
//   prod_out  62-bit product
//   done_out  one-cycle completion pulse
module mul_shift_add (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [30:0] a_in,
  input  logic [30:0] b_in,
  output logic [61:0] prod_out,
  output logic        done_out
);

  logic [61:0] acc;
  logic [61:0] a_sh;
  logic [30:0] b_sh;
  logic [4:0]  cnt;
  logic        busy;
  logic        done_r;

  // The load cycle also consumes multiplier bit 0, leaving 30 shift-add
  // steps so the finished product and done line up with cycle 32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start_in) begin
        acc  <= b_in[0] ? {31'd0, a_in} : '0;
        a_sh <= {30'd0, a_in, 1'b0};
        b_sh <= {1'b0, b_in[30:1]};
        cnt  <= 5'd30;
        busy <= 1'b1;
      end else if (busy) begin
        if (b_sh[0]) acc <= acc + a_sh;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          busy   <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign prod_out = acc;
  assign done_out = done_r;

endmodule

// File: rtl/vec_magnitude.sv
// |v| = sqrt(vx^2 + vy^2) for signed Q20.11 vectors. Squares both components
// on a shared sequential multiplier, saturates the sum, then initiates an
// external sqrt unit and reports its result (or a timeout).
//   clk_in, rst_in         clock, synchronous active-high reset
//   valid_in, vx_in, vy_in request; accepted when valid_in && ready_out
//   ready_out              high only while idle
//   valid_out              one-cycle result pulse
//   mag_out, sat_out, err_out  result fields, held until the next result
//   sqrt_rst_out           load pulse to the sqrt unit
//   sqrt_valid_out         enable level to the sqrt unit
//   sqrt_arg_out           sqrt operand (saturated sum of squares)
//   sqrt_result_in, sqrt_done_in  sqrt unit response
//
// state | meaning
// IDLE  | ready, waiting for a request
// SQ_X  | multiplier squaring |vx|
// SQ_Y  | multiplier squaring |vy|
// SUM   | add squares, saturate to Q_MAX
// LOAD  | one-cycle load pulse to the sqrt unit
// RUN   | sqrt enabled, waiting for done or timeout
// DONE  | result pulse
module vec_magnitude
  import vec_pkg::*;
#(
  parameter int INTEGER_BITS    = 20,
  parameter int FRACTIONAL_BITS = FRAC,
  parameter int SQRT_TIMEOUT    = 4096
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  fixed_t      vx_in,
  input  fixed_t      vy_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] mag_out,
  output logic        sat_out,
  output logic        err_out,
  output logic        sqrt_rst_out,
  output logic        sqrt_valid_out,
  output logic [31:0] sqrt_arg_out,
  input  logic [31:0] sqrt_result_in,
  input  logic        sqrt_done_in
);

  localparam int MAG_BITS = INTEGER_BITS + FRACTIONAL_BITS;
  localparam int TCNT_W   = $clog2(SQRT_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(SQRT_TIMEOUT - 1);

  vec_state_t          state;
  logic [MAG_BITS-1:0] ax, ay, sx, sy;
  logic                sat_acc;
  logic [31:0]         arg_r;
  logic [TCNT_W-1:0]   tcnt;
  logic                ready_r, sqrt_rst_r, sqrt_valid_r;
  logic                valid_r, sat_r, err_r;
  logic [31:0]         mag_r;

  logic                mul_start, mul_done;
  logic [61:0]         mul_prod;
  logic [MAG_BITS-1:0] mul_op;
  logic [61:0]         prod_shr;
  logic                sq_ovf;
  logic [MAG_BITS-1:0] sq_val;
  logic [32:0]         sum_full;
  logic                sum_ovf;

  // One multiplier serves both squarings; the operand follows the state.
  assign mul_op = (state == SQ_Y) ? ay : ax;

  mul_shift_add u_mul (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (mul_start),
    .a_in     (mul_op),
    .b_in     (mul_op),
    .prod_out (mul_prod),
    .done_out (mul_done)
  );

  always_comb begin
    prod_shr = mul_prod >> FRACTIONAL_BITS;
    sq_ovf   = |prod_shr[61:MAG_BITS];
    sq_val   = sq_ovf ? Q_MAX[MAG_BITS-1:0] : prod_shr[MAG_BITS-1:0];
    sum_full = {2'b00, sx} + {2'b00, sy};
    sum_ovf  = sum_full > {1'b0, Q_MAX};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      ax           <= '0;
      ay           <= '0;
      sx           <= '0;
      sy           <= '0;
      sat_acc      <= 1'b0;
      arg_r        <= '0;
      tcnt         <= '0;
      mul_start    <= 1'b0;
      ready_r      <= 1'b1;
      sqrt_rst_r   <= 1'b1;
      sqrt_valid_r <= 1'b0;
      valid_r      <= 1'b0;
      mag_r        <= '0;
      sat_r        <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          sqrt_rst_r <= 1'b0;
          if (valid_in && ready_r) begin
            ax        <= abs_sat(vx_in);
            ay        <= abs_sat(vy_in);
            sat_acc   <= is_min(vx_in) | is_min(vy_in);
            ready_r   <= 1'b0;
            mul_start <= 1'b1;
            state     <= SQ_X;
          end
        end
        SQ_X: begin
          if (mul_done) begin
            sx        <= sq_val;
            sat_acc   <= sat_acc | sq_ovf;
            mul_start <= 1'b1;
            state     <= SQ_Y;
          end
        end
        SQ_Y: begin
          if (mul_done) begin
            sy      <= sq_val;
            sat_acc <= sat_acc | sq_ovf;
            state   <= SUM;
          end
        end
        SUM: begin
          arg_r      <= sum_ovf ? Q_MAX : sum_full[31:0];
          sat_acc    <= sat_acc | sum_ovf;
          sqrt_rst_r <= 1'b1;
          tcnt       <= '0;
          state      <= LOAD;
        end
        LOAD: begin
          sqrt_rst_r   <= 1'b0;
          sqrt_valid_r <= 1'b1;
          state        <= RUN;
        end
        RUN: begin
          // done is tested first so it wins a tie with the timeout
          if (sqrt_done_in) begin
            mag_r        <= sqrt_result_in & Q_MAX;
            err_r        <= 1'b0;
            sat_r        <= sat_acc;
            valid_r      <= 1'b1;
            sqrt_valid_r <= 1'b0;
            state        <= DONE;
          end else if (tcnt == TCNT_LAST) begin
            mag_r        <= '0;
            err_r        <= 1'b1;
            sat_r        <= sat_acc;
            valid_r      <= 1'b1;
            sqrt_valid_r <= 1'b0;
            state        <= DONE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_out      = ready_r | rst_in;
  assign sqrt_rst_out   = sqrt_rst_r | rst_in;
  assign sqrt_valid_out = sqrt_valid_r;
  assign sqrt_arg_out   = arg_r;
  assign valid_out      = valid_r;
  assign mag_out        = mag_r;
  assign sat_out        = sat_r;
  assign err_out        = err_r;

endmodule

// File: tb/tb_vec_magnitude.sv
// Randomized and directed bench for vec_magnitude. A reference model computes
// the sqrt operand and magnitude with plain integer arithmetic; the bench also
// plays the external sqrt unit with a configurable done delay.
module tb_vec_magnitude;

  localparam int TMO = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [31:0] vx_in, vy_in;
  logic        ready_out, valid_out, sat_out, err_out;
  logic [31:0] mag_out;
  logic        sqrt_rst_out, sqrt_valid_out;
  logic [31:0] sqrt_arg_out;
  logic [31:0] sqrt_result_in;
  logic        sqrt_done_in;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  vec_magnitude #(.SQRT_TIMEOUT(TMO)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .vx_in          (vx_in),
    .vy_in          (vy_in),
    .ready_out      (ready_out),
    .valid_out      (valid_out),
    .mag_out        (mag_out),
    .sat_out        (sat_out),
    .err_out        (err_out),
    .sqrt_rst_out   (sqrt_rst_out),
    .sqrt_valid_out (sqrt_valid_out),
    .sqrt_arg_out   (sqrt_arg_out),
    .sqrt_result_in (sqrt_result_in),
    .sqrt_done_in   (sqrt_done_in)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint ref_abs(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s == -64'sd2147483648) return 64'd2147483647;
    return (s < 0) ? -s : s;
  endfunction

  // sqrt operand and saturation flag from the arithmetic rules alone
  task automatic ref_model(input logic [31:0] vx, input logic [31:0] vy,
                           output longint arg, output bit sat);
    longint ax, ay, sqx, sqy, s;
    longint qmax = 64'd2147483647;
    sat = (vx == 32'h8000_0000) || (vy == 32'h8000_0000);
    ax  = ref_abs(vx);
    ay  = ref_abs(vy);
    sqx = (ax * ax) / 2048;
    sqy = (ay * ay) / 2048;
    if (sqx > qmax) begin sqx = qmax; sat = 1'b1; end
    if (sqy > qmax) begin sqy = qmax; sat = 1'b1; end
    s = sqx + sqy;
    if (s > qmax) begin s = qmax; sat = 1'b1; end
    arg = s;
  endtask

  // One full transaction. Entered at a negedge with the DUT idle; returns at
  // the negedge of the following idle cycle. delay = cycles from RUN entry to
  // the sqrt done pulse (inclusive); 0 = never pulse. hold keeps valid_in high.
  task automatic run_vec(input logic [31:0] vx, input logic [31:0] vy,
                         input int delay, input bit hold, input string name);
    longint e_arg, e_mag;
    bit     e_sat;
    int     c = 0, load_c = -1, run_c = -1, vc = -1, busy_ready = 0, n_sqrt;
    logic [31:0] got_arg = '0, got_mag = '0;
    logic        got_sat = 1'b0, got_err = 1'b0, dropped = 1'b0;

    ref_model(vx, vy, e_arg, e_sat);
    n_sqrt = (delay > 0) ? delay : TMO;
    e_mag  = (delay > 0) ? isqrt(e_arg * 2048) : 0;

    check_val({name, ":ready_idle"}, ready_out, 1);
    valid_in = 1'b1;
    vx_in    = vx;
    vy_in    = vy;
    @(posedge clk_in);
    while (c < 400) begin
      @(negedge clk_in);
      c++;
      if (!hold) valid_in = 1'b0;
      vx_in        = $urandom;
      vy_in        = $urandom;
      sqrt_done_in = 1'b0;
      if (vc > 0 && c == vc + 1) begin
        check_val({name, ":ready_after"}, ready_out, 1);
        check_val({name, ":valid_single"}, valid_out, 0);
        check_val({name, ":sqrt_valid_after"}, sqrt_valid_out, 0);
        dropped = 1'b1;
        break;
      end
      if (ready_out) busy_ready++;
      if (sqrt_rst_out && load_c < 0) begin
        load_c  = c;
        got_arg = sqrt_arg_out;
      end
      if (sqrt_valid_out && run_c < 0) run_c = c;
      if (c == 5) begin
        sqrt_done_in   = 1'b1;
        sqrt_result_in = $urandom;
      end
      if (run_c > 0 && delay > 0 && c == run_c + delay - 1) begin
        sqrt_done_in   = 1'b1;
        sqrt_result_in = 32'(isqrt(longint'(sqrt_arg_out) * 2048));
      end
      if (valid_out && vc < 0) begin
        vc      = c;
        got_mag = mag_out;
        got_sat = sat_out;
        got_err = err_out;
      end
    end
    sqrt_done_in = 1'b0;
    check_val({name, ":completed"}, dropped, 1);
    check_val({name, ":load_cycle"}, load_c, 66);
    check_val({name, ":run_cycle"}, run_c, 67);
    check_val({name, ":latency"}, vc, 67 + n_sqrt);
    check_val({name, ":busy_ready"}, busy_ready, 0);
    check_val({name, ":arg"}, got_arg, e_arg);
    check_val({name, ":mag"}, got_mag, e_mag);
    check_val({name, ":sat"}, got_sat, e_sat);
    check_val({name, ":err"}, got_err, (delay == 0));
  endtask

  function automatic logic [31:0] pick_comp();
    logic [31:0] m;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: m = $urandom_range(0, 1 << 20);
      2: m = $urandom_range(0, 1 << 27);
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_0000;
          1: return 32'h8000_0000;
          2: return 32'h7FFF_FFFF;
          3: return 32'hFFFF_FFFF;
          default: return 32'h0000_0001;
        endcase
      end
    endcase
    return $urandom_range(0, 1) ? -m : m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst_in         = 1'b1;
    valid_in       = 1'b0;
    vx_in          = '0;
    vy_in          = '0;
    sqrt_result_in = '0;
    sqrt_done_in   = 1'b0;

    repeat (3) @(negedge clk_in);
    check_val("rst:ready", ready_out, 1);
    check_val("rst:sqrt_rst", sqrt_rst_out, 1);
    check_val("rst:valid", valid_out, 0);
    check_val("rst:mag", mag_out, 0);
    check_val("rst:sat", sat_out, 0);
    check_val("rst:err", err_out, 0);
    check_val("rst:sqrt_valid", sqrt_valid_out, 0);
    check_val("rst:sqrt_arg", sqrt_arg_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check_val("post_rst:sqrt_rst", sqrt_rst_out, 0);

    run_vec(32'h0000_1800, 32'h0000_2000, 5, 1'b0, "v34");
    check_val("v34:mag_const", mag_out, 32'h0000_2800);
    run_vec(32'hFFFF_E800, 32'hFFFF_E000, 12, 1'b0, "neg34");
    check_val("neg34:mag_const", mag_out, 32'h0000_2800);
    run_vec(32'h7FFF_FFFF, 32'h0000_0000, 3, 1'b0, "satx");
    check_val("satx:sat_const", sat_out, 1);
    run_vec(32'h0000_0000, 32'h0000_0000, 1, 1'b0, "zero");
    check_val("zero:mag_const", mag_out, 0);
    run_vec(32'h8000_0000, 32'h0000_1000, 7, 1'b0, "minx");
    run_vec(32'h0000_1800, 32'h0000_2000, 0, 1'b0, "tmo");
    check_val("tmo:mag_hold", mag_out, 0);
    check_val("tmo:err_hold", err_out, 1);
    run_vec(32'h0000_1800, 32'h0000_2000, TMO, 1'b0, "tie");

    run_vec(32'h0001_0000, 32'hFFFF_0000, 4, 1'b1, "hold0");
    run_vec(32'h0000_0800, 32'h0003_0000, 9, 1'b1, "hold1");
    run_vec(32'hFFF0_0000, 32'h0000_0000, 2, 1'b0, "hold2");

    // reset while squaring y
    valid_in = 1'b1;
    vx_in    = 32'h0000_1800;
    vy_in    = 32'h0000_2000;
    @(posedge clk_in);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      valid_in = 1'b0;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_val("midrst:ready", ready_out, 1);
    check_val("midrst:sqrt_valid", sqrt_valid_out, 0);
    vcount = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (valid_out) vcount++;
    end
    check_val("midrst:no_valid", vcount, 0);
    run_vec(32'h0000_2000, 32'h0000_1800, 6, 1'b0, "after_rst");

    for (int t = 0; t < 16; t++) begin
      logic [31:0] rx, ry;
      int d;
      rx = pick_comp();
      ry = pick_comp();
      d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      run_vec(rx, ry, d, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
